psi_period_meter: RTL and testbench

Measures the period of the regulated PSI output in clk_50M cycles and reports a running average, an in-range flag against the requested setPeriod, and a stall indication. It sits on the consuming side of the frequency regulator/divider: the regulator writes a PSI waveform at the requested period, and this block reads it back for closed-loop checking and for the display and test logic. PSI is asynchronous to clk_50M and is synchronized internally.

---
 rtl/psi_period_meter.sv | 152 +++++++++++++++
 tb/tb_psi_period_meter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/psi_period_meter.sv
// PSI period meter: synchronizes PSI, times rise-to-rise intervals in clk_50M
// cycles, averages 2^AVG_LOG intervals and flags in-range / stalled input.
module psi_period_meter #(
  parameter int unsigned W       = 16,
  parameter int unsigned AVG_LOG = 2,
  parameter int unsigned TOL     = 2
) (
  input  logic         clk_50M,
  input  logic         rst,
  input  logic         en,
  input  logic         PSI,
  input  logic [7:0]   setPeriod,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         in_range,
  output logic         stopped
);

  localparam int unsigned AW = W + AVG_LOG;
  localparam int unsigned NW = AVG_LOG + 1;
  localparam logic [W-1:0]  CNT_MAX = '1;
  localparam logic [NW-1:0] NS_LAST = NW'((32'd1 << AVG_LOG) - 32'd1);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [NW-1:0] nsamp_q, nsamp_d;
  logic [W-1:0]  period_q, period_d;
  logic          valid_q, valid_d;
  logic          in_range_q, in_range_d;
  logic          stopped_q, stopped_d;

  logic          rise_c;
  logic [AW-1:0] sum_c;
  logic [W-1:0]  avg_c;
  logic [W-1:0]  set_ext_c;
  logic [W-1:0]  diff_c;

  assign rise_c    = s2_q & ~s3_q;
  assign sum_c     = acc_q + AW'(cnt_q);
  assign avg_c     = W'(sum_c >> AVG_LOG);
  assign set_ext_c = W'(setPeriod);
  assign diff_c    = (avg_c >= set_ext_c) ? (avg_c - set_ext_c) : (set_ext_c - avg_c);

  // Three-flop synchronizer for the asynchronous PSI input.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= PSI;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      nsamp_q    <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      in_range_q <= 1'b0;
      stopped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      nsamp_q    <= nsamp_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      in_range_q <= in_range_d;
      stopped_q  <= stopped_d;
    end
  end

  // Next-state: first edge arms the meter, each later rise closes an interval,
  // a saturated counter without a rise reports a stall and disarms.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    nsamp_d    = nsamp_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    in_range_d = in_range_q;
    stopped_d  = stopped_q;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      nsamp_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          acc_d   = '0;
          nsamp_d = '0;
          if (rise_c) begin
            state_d = MEAS;
            cnt_d   = W'(1);
          end
        end
        MEAS: begin
          if (rise_c) begin
            cnt_d = W'(1);
            if (nsamp_q == NS_LAST) begin
              period_d   = avg_c;
              valid_d    = 1'b1;
              in_range_d = (diff_c <= W'(TOL));
              stopped_d  = 1'b0;
              acc_d      = '0;
              nsamp_d    = '0;
            end else begin
              acc_d   = sum_c;
              nsamp_d = nsamp_q + NW'(1);
            end
          end else if (cnt_q == CNT_MAX) begin
            period_d   = '1;
            stopped_d  = 1'b1;
            in_range_d = 1'b0;
            valid_d    = 1'b1;
            cnt_d      = '0;
            acc_d      = '0;
            nsamp_d    = '0;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign in_range     = in_range_q;
  assign stopped      = stopped_q;

endmodule

// File: tb/tb_psi_period_meter.sv
// Scoreboard bench for psi_period_meter (W=8 so the stall path is short).
module tb_psi_period_meter;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] p;
    logic         ir;
    logic         st;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         psi = 1'b0;
  logic [7:0]   set_period = 8'd8;
  logic [W-1:0] period;
  logic         period_valid;
  logic         in_range;
  logic         stopped;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pulse_cyc = 0;
  int   prev_pulse_cyc = 0;

  psi_period_meter #(.W(W), .AVG_LOG(2), .TOL(2)) dut (
    .clk_50M      (clk),
    .rst          (rst_n),
    .en           (en),
    .PSI          (psi),
    .setPeriod    (set_period),
    .period       (period),
    .period_valid (period_valid),
    .in_range     (in_range),
    .stopped      (stopped)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every period_valid pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && period_valid) begin
      prev_pulse_cyc = pulse_cyc;
      pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got period=%0d in_range=%0d stopped=%0d, expected no pulse (t=%0t)",
                 period, in_range, stopped, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (period !== e.p || in_range !== e.ir || stopped !== e.st) begin
          errors++;
          $display("FAIL pulse: got period=%0d in_range=%0d stopped=%0d, expected period=%0d in_range=%0d stopped=%0d (t=%0t)",
                   period, in_range, stopped, e.p, e.ir, e.st, $time);
        end
      end
    end
  end

  // One PSI period: rise now, high for p/2 cycles, low for the rest.
  task automatic gen(input int p);
    psi = 1'b1;
    repeat (p / 2) @(negedge clk);
    psi = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic push(input int p, input bit ir, input bit st);
    exp_t e;
    e.p  = W'(p);
    e.ir = ir;
    e.st = st;
    exp_q.push_back(e);
  endtask

  // Four intervals; the next rise (from the following gen) closes the average.
  task automatic group(input int a, input int b, input int c, input int d,
                       input int ep, input bit eir);
    gen(a);
    gen(b);
    gen(c);
    gen(d);
    push(ep, eir, 1'b0);
  endtask

  task automatic close_and_drain(input string name);
    gen(8);
    repeat (6) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic restart_en();
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
  endtask

  int rise_cyc;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_period", period, 0);
    chk("reset_valid", period_valid, 0);
    chk("reset_in_range", in_range, 0);
    chk("reset_stopped", stopped, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Steady 8-cycle input, then 7/9 alternation and truncation.
    set_period = 8'd8;
    en = 1'b1;
    group(8, 8, 8, 8, 8, 1'b1);
    group(8, 8, 8, 8, 8, 1'b1);
    group(7, 9, 7, 9, 8, 1'b1);
    chk("steady_cadence", pulse_cyc - prev_pulse_cyc, 32);
    group(7, 7, 7, 8, 7, 1'b1);
    close_and_drain("t1_pending");

    // Out-of-range setpoint, then a change that only lands at the next pulse.
    set_period = 8'd125;
    restart_en();
    group(8, 8, 8, 8, 8, 1'b0);
    gen(8);
    set_period = 8'd10;
    @(negedge clk);
    chk("setp_change_no_immediate", in_range, 0);
    gen(8);
    chk("setp_change_held", in_range, 0);
    gen(8);
    gen(8);
    push(8, 1'b1, 1'b0);
    close_and_drain("t3_pending");

    // Stall after steady operation: one pulse 255 cycles after the last load.
    set_period = 8'd8;
    restart_en();
    group(8, 8, 8, 8, 8, 1'b1);
    push(255, 1'b0, 1'b1);
    rise_cyc = cyc;
    gen(8);
    repeat (300) @(negedge clk);
    chk("stall_latency", pulse_cyc - rise_cyc, 258);
    chk("stall_pending", exp_q.size(), 0);
    chk("stall_stopped_held", stopped, 1);
    group(8, 8, 8, 8, 8, 1'b1);
    close_and_drain("restart_pending");

    // Reset after two samples of a fresh average.
    restart_en();
    gen(8);
    gen(8);
    gen(8);
    chk("pre_reset_period", period, 8);
    rst_n = 1'b0;
    #1;
    chk("midrst_period", period, 0);
    chk("midrst_in_range", in_range, 0);
    chk("midrst_stopped", stopped, 0);
    chk("midrst_valid", period_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    group(8, 8, 8, 8, 8, 1'b1);
    close_and_drain("post_reset_pending");

    // Enable dropped for 50 cycles mid-average while PSI keeps running.
    gen(9);
    gen(9);
    en = 1'b0;
    repeat (5) gen(10);
    chk("en_off_period_held", period, 8);
    chk("en_off_in_range_held", in_range, 1);
    en = 1'b1;
    group(9, 9, 9, 9, 9, 1'b1);
    close_and_drain("en_restart_pending");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
